// File: rtl/dt1_pkg.sv
// Shared definitions for the dt1 pipeline memory arbiter: FSM state
// encoding and the transaction-owner constants.
package dt1_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;

endpackage

// File: rtl/dt1_mem_arbiter.sv
// Single-port memory arbiter for the dt1 pipeline.
// Serializes fetch and data requests onto one req/gnt/rvalid port with a
// single transaction outstanding. Data has strict priority over fetch.
// A fetch killed by a redirect still completes on the port, but its
// response is dropped.
//
// Handshake: in REQ, mem_req is held high with all request fields stable
// until the cycle mem_gnt is seen; the request is never withdrawn. After
// the grant, exactly one mem_rvalid cycle in WAIT completes the
// transaction; mem_rvalid in any other state is ignored.
module dt1_mem_arbiter
    import dt1_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    // fetch side
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    input  logic            if_kill,
    output logic [DW-1:0]   if_rdata,
    output logic            if_valid,
    // data side
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    input  logic [DW/8-1:0] dm_be,
    output logic [DW-1:0]   dm_rdata,
    output logic            dm_valid,
    // stall terms for the hazard unit
    output logic            stall_if,
    output logic            stall_dm,
    // memory port
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);

    arb_state_e      state_q;
    logic            owner_q;
    logic            stale_q;
    logic            mem_req_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] be_q;

    logic            in_wait;
    logic            resp_fire;

    // Arbitration FSM with registered request fields and owner/stale flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWNER_IF;
            stale_q   <= 1'b0;
            mem_req_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    stale_q <= 1'b0;
                    if (dm_req) begin
                        owner_q   <= OWNER_DM;
                        we_q      <= dm_we;
                        addr_q    <= dm_addr;
                        wdata_q   <= dm_wdata;
                        be_q      <= dm_be;
                        mem_req_q <= 1'b1;
                        state_q   <= REQ;
                    end else if (if_req) begin
                        owner_q   <= OWNER_IF;
                        we_q      <= 1'b0;
                        addr_q    <= if_addr;
                        wdata_q   <= '0;
                        be_q      <= '1;
                        mem_req_q <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (if_kill && owner_q == OWNER_IF) begin
                        stale_q <= 1'b1;
                    end
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (if_kill && owner_q == OWNER_IF) begin
                        stale_q <= 1'b1;
                    end
                    // Completion wins over a same-cycle kill: stale clears on entry to IDLE.
                    if (mem_rvalid) begin
                        stale_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    stale_q   <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // Completion decode and combinational stall terms
    always_comb begin
        in_wait   = (state_q == WAIT);
        resp_fire = mem_rvalid && in_wait;
        if_valid  = resp_fire && (owner_q == OWNER_IF) && !stale_q && !if_kill;
        dm_valid  = resp_fire && (owner_q == OWNER_DM);
        if_rdata  = mem_rdata;
        dm_rdata  = mem_rdata;
        stall_if  = if_req && !if_valid;
        stall_dm  = dm_req && !dm_valid;
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

endmodule

// File: tb/tb_dt1_mem_arbiter.sv
// Directed testbench for dt1_mem_arbiter. Inputs change just after the
// falling edge; outputs are sampled 1ns later, away from the rising edge.
module tb_dt1_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        stall_if;
    logic        stall_dm;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    dt1_mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_kill    (if_kill),
        .if_rdata   (if_rdata),
        .if_valid   (if_valid),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_be      (dm_be),
        .dm_rdata   (dm_rdata),
        .dm_valid   (dm_valid),
        .stall_if   (stall_if),
        .stall_dm   (stall_dm),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        if_req     = 1'b0;
        if_addr    = '0;
        if_kill    = 1'b0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        dm_addr    = '0;
        dm_wdata   = '0;
        dm_be      = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        tests_run++;
        if ({mem_req, mem_we, mem_be, if_valid, dm_valid} !== 8'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected %b", {mem_req, mem_we, mem_be, if_valid, dm_valid}, 8'b0);
        end
        tests_run++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_fields: got %h expected %h", {mem_addr, mem_wdata}, 64'h0);
        end
        repeat (2) @(negedge clk);
        mem_rvalid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if ({mem_req, if_valid, dm_valid, stall_if, stall_dm} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got %b expected %b", {mem_req, if_valid, dm_valid, stall_if, stall_dm}, 5'b0);
        end
    endtask

    task automatic test_fetch();
        // c0: request seen in IDLE
        @(negedge clk); if_req = 1'b1; if_addr = 32'h0000_0010; #1;
        tests_run++;
        if ({mem_req, if_valid, stall_if} !== 3'b001) begin
            tests_failed++;
            $display("FAIL fetch_c0: got %b expected %b", {mem_req, if_valid, stall_if}, 3'b001);
        end
        // c1: mem_req with immediate grant
        @(negedge clk); mem_gnt = 1'b1; #1;
        tests_run++;
        if ({mem_req, mem_we, mem_be, if_valid, stall_if} !== 8'b1011_1101) begin
            tests_failed++;
            $display("FAIL fetch_c1: got %b expected %b", {mem_req, mem_we, mem_be, if_valid, stall_if}, 8'b1011_1101);
        end
        tests_run++;
        if (mem_addr !== 32'h0000_0010) begin
            tests_failed++;
            $display("FAIL fetch_addr: got %h expected %h", mem_addr, 32'h0000_0010);
        end
        // c2: response completes the fetch
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093; #1;
        tests_run++;
        if ({mem_req, if_valid, stall_if, dm_valid} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL fetch_c2: got %b expected %b", {mem_req, if_valid, stall_if, dm_valid}, 4'b0100);
        end
        tests_run++;
        if (if_rdata !== 32'h0050_0093) begin
            tests_failed++;
            $display("FAIL fetch_rdata: got %h expected %h", if_rdata, 32'h0050_0093);
        end
        // c3: back in IDLE, single-cycle valid
        @(negedge clk); mem_rvalid = 1'b0; if_req = 1'b0; #1;
        tests_run++;
        if ({mem_req, if_valid, stall_if} !== 3'b000) begin
            tests_failed++;
            $display("FAIL fetch_c3: got %b expected %b", {mem_req, if_valid, stall_if}, 3'b000);
        end
    endtask

    task automatic test_contention();
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0100; dm_be = 4'b1111;
        if_req = 1'b1; if_addr = 32'h0000_0020; #1;
        tests_run++;
        if ({mem_req, stall_if, stall_dm} !== 3'b011) begin
            tests_failed++;
            $display("FAIL cont_c0: got %b expected %b", {mem_req, stall_if, stall_dm}, 3'b011);
        end
        @(negedge clk); mem_gnt = 1'b1; #1;
        tests_run++;
        if ({mem_req, mem_we, stall_if} !== 3'b101 || mem_addr !== 32'h0000_0100) begin
            tests_failed++;
            $display("FAIL cont_load_issue: got %b/%h expected %b/%h", {mem_req, mem_we, stall_if}, mem_addr, 3'b101, 32'h0000_0100);
        end
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001; #1;
        tests_run++;
        if ({dm_valid, if_valid, stall_dm, stall_if} !== 4'b1001 || dm_rdata !== 32'hCAFE_0001) begin
            tests_failed++;
            $display("FAIL cont_load_done: got %b/%h expected %b/%h", {dm_valid, if_valid, stall_dm, stall_if}, dm_rdata, 4'b1001, 32'hCAFE_0001);
        end
        // load consumed; FSM back in IDLE picks up the waiting fetch
        @(negedge clk); dm_req = 1'b0; mem_rvalid = 1'b0; #1;
        tests_run++;
        if ({mem_req, stall_if, if_valid} !== 3'b010) begin
            tests_failed++;
            $display("FAIL cont_idle: got %b expected %b", {mem_req, stall_if, if_valid}, 3'b010);
        end
        @(negedge clk); mem_gnt = 1'b1; #1;
        tests_run++;
        if ({mem_req, stall_if} !== 2'b11 || mem_addr !== 32'h0000_0020) begin
            tests_failed++;
            $display("FAIL cont_fetch_issue: got %b/%h expected %b/%h", {mem_req, stall_if}, mem_addr, 2'b11, 32'h0000_0020);
        end
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; #1;
        tests_run++;
        if ({if_valid, stall_if} !== 2'b10 || if_rdata !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL cont_fetch_done: got %b/%h expected %b/%h", {if_valid, stall_if}, if_rdata, 2'b10, 32'h1234_5678);
        end
        @(negedge clk); clear_inputs();
    endtask

    task automatic test_store();
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0204;
        dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011;
        // three REQ cycles without grant; stray rvalid and input changes ignored
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_rvalid = (i == 0);
            dm_addr = 32'h0000_0999;
            dm_wdata = 32'h0;
            #1;
            tests_run++;
            if ({mem_req, mem_we, mem_be, dm_valid, stall_dm} !== 8'b1100_1101 ||
                mem_addr !== 32'h0000_0204 || mem_wdata !== 32'hDEAD_BEEF) begin
                tests_failed++;
                $display("FAIL store_hold%0d: got %b/%h/%h expected %b/%h/%h", i,
                         {mem_req, mem_we, mem_be, dm_valid, stall_dm}, mem_addr, mem_wdata,
                         8'b1100_1101, 32'h0000_0204, 32'hDEAD_BEEF);
            end
        end
        @(negedge clk); mem_rvalid = 1'b0; mem_gnt = 1'b1; #1;
        tests_run++;
        if ({mem_req, dm_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL store_gnt: got %b expected %b", {mem_req, dm_valid}, 2'b10);
        end
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; #1;
        tests_run++;
        if ({mem_req, dm_valid, stall_dm} !== 3'b010) begin
            tests_failed++;
            $display("FAIL store_ack: got %b expected %b", {mem_req, dm_valid, stall_dm}, 3'b010);
        end
        @(negedge clk); clear_inputs();
    endtask

    task automatic test_kill();
        @(negedge clk); if_req = 1'b1; if_addr = 32'h0000_0040;
        @(negedge clk); mem_gnt = 1'b1;
        // WAIT: redirect arrives before the response
        @(negedge clk); mem_gnt = 1'b0; if_kill = 1'b1; if_addr = 32'h0000_0080;
        @(negedge clk); if_kill = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111; #1;
        tests_run++;
        if ({if_valid, stall_if} !== 2'b01) begin
            tests_failed++;
            $display("FAIL kill_drop: got %b expected %b", {if_valid, stall_if}, 2'b01);
        end
        @(negedge clk); mem_rvalid = 1'b0;
        @(negedge clk); mem_gnt = 1'b1; #1;
        tests_run++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0080}) begin
            tests_failed++;
            $display("FAIL kill_refetch: got %b/%h expected %b/%h", mem_req, mem_addr, 1'b1, 32'h0000_0080);
        end
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222; #1;
        tests_run++;
        if ({if_valid, if_rdata} !== {1'b1, 32'h2222_2222}) begin
            tests_failed++;
            $display("FAIL kill_new_done: got %b/%h expected %b/%h", if_valid, if_rdata, 1'b1, 32'h2222_2222);
        end
        @(negedge clk); clear_inputs();
    endtask

    task automatic test_kill_same_cycle();
        @(negedge clk); if_req = 1'b1; if_addr = 32'h0000_0090;
        @(negedge clk); mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; if_kill = 1'b1; mem_rdata = 32'h3333_3333; #1;
        tests_run++;
        if ({if_valid, stall_if} !== 2'b01) begin
            tests_failed++;
            $display("FAIL kill_same_cycle: got %b expected %b", {if_valid, stall_if}, 2'b01);
        end
        @(negedge clk); clear_inputs(); #1;
        tests_run++;
        if ({mem_req, if_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL kill_same_idle: got %b expected %b", {mem_req, if_valid}, 2'b00);
        end
    endtask

    task automatic test_kill_during_data();
        @(negedge clk); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0300; dm_be = 4'b1111;
        @(negedge clk); mem_gnt = 1'b1; if_kill = 1'b1;
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h4444_4444; #1;
        tests_run++;
        if ({dm_valid, if_valid, stall_dm} !== 3'b100 || dm_rdata !== 32'h4444_4444) begin
            tests_failed++;
            $display("FAIL kill_data: got %b/%h expected %b/%h", {dm_valid, if_valid, stall_dm}, dm_rdata, 3'b100, 32'h4444_4444);
        end
        @(negedge clk); clear_inputs();
    endtask

    task automatic test_async_reset();
        // reset during REQ drops mem_req without a clock edge
        @(negedge clk); if_req = 1'b1; if_addr = 32'h0000_00A0;
        @(negedge clk); #1;
        tests_run++;
        if (mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL arst_pre_req: got %b expected %b", mem_req, 1'b1);
        end
        #1 rst_n = 1'b0; #1;
        tests_run++;
        if ({mem_req, mem_addr} !== 33'h0) begin
            tests_failed++;
            $display("FAIL arst_req_drop: got %b/%h expected %b/%h", mem_req, mem_addr, 1'b0, 32'h0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); mem_gnt = 1'b1; #1;
        tests_run++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0000_00A0}) begin
            tests_failed++;
            $display("FAIL arst_restart: got %b/%h expected %b/%h", mem_req, mem_addr, 1'b1, 32'h0000_00A0);
        end
        // reset during WAIT with response present kills the valid immediately
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555; #1;
        tests_run++;
        if (if_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL arst_pre_valid: got %b expected %b", if_valid, 1'b1);
        end
        #1 rst_n = 1'b0; #1;
        tests_run++;
        if ({mem_req, if_valid, dm_valid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL arst_wait: got %b expected %b", {mem_req, if_valid, dm_valid}, 3'b000);
        end
        @(negedge clk); clear_inputs(); rst_n = 1'b1;
        // clean fetch after release
        @(negedge clk); if_req = 1'b1; if_addr = 32'h0000_00B0;
        @(negedge clk); mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h6666_6666; #1;
        tests_run++;
        if ({if_valid, if_rdata} !== {1'b1, 32'h6666_6666} || mem_addr !== 32'h0000_00B0) begin
            tests_failed++;
            $display("FAIL arst_clean_fetch: got %b/%h/%h expected %b/%h/%h", if_valid, if_rdata, mem_addr, 1'b1, 32'h6666_6666, 32'h0000_00B0);
        end
        @(negedge clk); clear_inputs();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_contention();
        test_store();
        test_kill();
        test_kill_same_cycle();
        test_kill_during_data();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
